// File: rtl/mem_arbiter_if.sv
// Bundle of requester, backing-memory and response signals for mem_arbiter.
// The arbiter sits on the slave side; the surrounding system drives the master side.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        resp_valid;
    logic        resp_owner;
    logic [2:0]  resp_idx;
    logic [31:0] resp_data;
    logic        i_done;
    logic        d_done;
    logic        stall_if;
    logic        stall_mem;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output resp_valid, resp_owner, resp_idx, resp_data,
        output i_done, d_done, stall_if, stall_mem
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  resp_valid, resp_owner, resp_idx, resp_data,
        input  i_done, d_done, stall_if, stall_mem
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one backing memory between an instruction-line fill port and a
// single-word data port; data side wins ties, every transaction ends in a one-cycle DONE.
//
// state  | meaning
// IDLE   | sample requests, grant data side first
// I_FILL | instruction line burst, one word per mem_ready
// D_RD   | single data load
// D_WR   | single data store
// DONE   | completion pulse, forced return to IDLE
module mem_arbiter #(
    parameter int WORDS_PER_LINE = 4
) (
    input logic         CLK,
    input logic         RST_N,
    mem_arbiter_if.slave bus
);
    localparam logic [2:0]  LAST_BEAT = 3'(WORDS_PER_LINE - 1);
    localparam logic [29:0] LINE_MASK = ~30'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {IDLE, I_FILL, D_RD, D_WR, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  beat_q, beat_d;
    logic [29:0] base_q, base_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        i_done_q, i_done_d;
    logic        d_done_q, d_done_d;
    logic [2:0]  beat_nxt;
    logic [29:0] i_line;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^{bus.i_addr[1:0], bus.d_addr[1:0]};
    assign beat_nxt        = beat_q + 3'd1;
    assign i_line          = bus.i_addr[31:2] & LINE_MASK;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            base_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            base_q      <= base_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        base_d      = base_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.d_req) begin
                    base_d      = bus.d_addr[31:2];
                    beat_d      = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = {bus.d_addr[31:2], 2'b00};
                    mem_wdata_d = bus.d_wdata;
                    state_d     = bus.d_we ? D_WR : D_RD;
                end else if (bus.i_req) begin
                    base_d     = i_line;
                    beat_d     = '0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {i_line, 2'b00};
                    state_d    = I_FILL;
                end
            end
            I_FILL: begin
                if (bus.mem_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d    = '0;
                        mem_req_d = 1'b0;
                        i_done_d  = 1'b1;
                        state_d   = DONE;
                    end else begin
                        beat_d     = beat_nxt;
                        mem_addr_d = {base_q | {27'd0, beat_nxt}, 2'b00};
                    end
                end
            end
            D_RD, D_WR: begin
                if (bus.mem_ready) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    d_done_d  = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read responses are a same-cycle pass-through of the memory word.
    always_comb begin
        bus.resp_valid = 1'b0;
        bus.resp_owner = 1'b0;
        bus.resp_idx   = '0;
        bus.resp_data  = '0;
        if (RST_N && bus.mem_ready) begin
            if (state_q == I_FILL) begin
                bus.resp_valid = 1'b1;
                bus.resp_idx   = beat_q;
                bus.resp_data  = bus.mem_rdata;
            end else if (state_q == D_RD) begin
                bus.resp_valid = 1'b1;
                bus.resp_owner = 1'b1;
                bus.resp_data  = bus.mem_rdata;
            end
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_done    = i_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.stall_mem = RST_N & bus.d_req & ~d_done_q;
    assign bus.stall_if  = RST_N & ((bus.i_req & ~i_done_q) | (bus.d_req & ~d_done_q));
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts the
// memory beats, responses, done pulses and stalls seen each cycle.
module tb_mem_arbiter;
    localparam int W      = 4;
    localparam int CYCLES = 4000;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        owner;
        logic [2:0]  idx;
    } beat_t;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    mem_arbiter_if bus();
    mem_arbiter #(.WORDS_PER_LINE(W)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

    beat_t q[$];
    int    n_chk = 0;
    int    n_bad = 0;
    int    n_txn = 0;
    int    done_now = -1;
    int    prev_done = -1;
    bit    i_wait = 0;
    bit    i_granted = 0;
    bit    did_fill_rst = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic grant_model();
        beat_t b;
        logic [31:0] base;
        if (bus.d_req) begin
            b.addr  = {bus.d_addr[31:2], 2'b00};
            b.we    = bus.d_we;
            b.wdata = bus.d_wdata;
            b.owner = 1'b1;
            b.idx   = 3'd0;
            q.push_back(b);
        end else if (bus.i_req) begin
            base = bus.i_addr & ~(32'(W * 4 - 1));
            for (int k = 0; k < W; k++) begin
                b.addr  = base + 32'(4 * k);
                b.we    = 1'b0;
                b.wdata = '0;
                b.owner = 1'b0;
                b.idx   = 3'(k);
                q.push_back(b);
            end
            i_granted = 1'b1;
        end
    endtask

    initial begin
        bit rst, fire, was_empty, exp_rv, exp_smem, exp_sif;
        int nxt_done, pct;
        bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.mem_ready = 0; bus.mem_rdata = '0;
        repeat (2) @(posedge CLK);

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(posedge CLK);
            #1;
            rst = (cyc < 2) || ($urandom_range(0, 599) == 0);
            if (!did_fill_rst && q.size() == W - 2 && q.size() > 0 && q[0].owner == 1'b0) begin
                rst = 1'b1;
                did_fill_rst = 1'b1;
            end
            if (rst) begin
                RST_N = 1'b0;
                bus.i_req = 0; bus.d_req = 0;
                i_wait = 0; i_granted = 0;
            end else begin
                RST_N = 1'b1;
                if (prev_done == 0) begin
                    bus.i_req = 0; i_wait = 0; i_granted = 0;
                end
                if (prev_done == 1) bus.d_req = 0;
                if (!bus.i_req && !i_wait && $urandom_range(0, 99) < 15) begin
                    bus.i_req  = 1;
                    bus.i_addr = $urandom();
                end else if (bus.i_req && i_granted && $urandom_range(0, 99) < 8) begin
                    bus.i_req = 0;
                    i_wait    = 1;
                end
                if (!bus.d_req && $urandom_range(0, 99) < 15) begin
                    bus.d_req   = 1;
                    bus.d_we    = 1'($urandom_range(0, 1));
                    bus.d_addr  = $urandom();
                    bus.d_wdata = $urandom();
                end
            end
            pct = (cyc < 300) ? 100 : 55;
            bus.mem_ready = ($urandom_range(0, 99) < pct);
            bus.mem_rdata = $urandom();

            @(negedge CLK);
            chk("mem_req", 32'(bus.mem_req), 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("mem_addr", bus.mem_addr, q[0].addr);
                chk("mem_we", 32'(bus.mem_we), 32'(q[0].we));
                if (q[0].we) chk("mem_wdata", bus.mem_wdata, q[0].wdata);
            end
            fire   = RST_N && bus.mem_ready && (q.size() > 0);
            exp_rv = fire && !q[0].we;
            chk("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
            if (exp_rv) begin
                chk("resp_owner", 32'(bus.resp_owner), 32'(q[0].owner));
                chk("resp_idx", 32'(bus.resp_idx), 32'(q[0].idx));
                chk("resp_data", bus.resp_data, bus.mem_rdata);
            end
            chk("i_done", 32'(bus.i_done), 32'(done_now == 0));
            chk("d_done", 32'(bus.d_done), 32'(done_now == 1));
            exp_smem = RST_N && bus.d_req && (done_now != 1);
            exp_sif  = RST_N && ((bus.i_req && (done_now != 0)) || exp_smem);
            chk("stall_mem", 32'(bus.stall_mem), 32'(exp_smem));
            chk("stall_if", 32'(bus.stall_if), 32'(exp_sif));

            prev_done = done_now;
            nxt_done  = -1;
            if (!RST_N) begin
                q.delete();
            end else begin
                was_empty = (q.size() == 0);
                if (fire) begin
                    if (q.size() == 1) begin
                        nxt_done = q[0].owner ? 1 : 0;
                        n_txn++;
                    end
                    void'(q.pop_front());
                end
                if (was_empty && done_now < 0) grant_model();
            end
            done_now = nxt_done;
        end

        chk("progress", 32'(n_txn > 50), 32'd1);
        chk("fill_reset_hit", 32'(did_fill_rst), 32'd1);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORDS_PER_LINE, default 4, meaning words per instruction-line fill burst; legal values 2, 4, 8.
REQ-002 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port RST_N  input  1  reset: one clock; reset is synchronous and active-low.
REQ-004 SHALL have port i_req  input  1  instruction-cache miss request; held by requester until i_done.
REQ-005 SHALL have port i_addr  input  32  miss address; bits [1:0] ignored.
REQ-006 SHALL have port d_req  input  1  data access request; held until d_done.
REQ-007 SHALL have port d_we  input  1  1 = store word, 0 = load word.
REQ-008 SHALL have port d_addr  input  32  data word address; bits [1:0] ignored.
REQ-009 SHALL have port d_wdata  input  32  store data.
REQ-010 SHALL have port mem_ready  input  1  backing memory accepts write or returns read word this cycle.
REQ-011 SHALL have port mem_rdata  input  32  read word, valid when mem_ready=1 on a read.
REQ-012 SHALL have port mem_req  output  1  access request to backing memory.
REQ-013 SHALL have port mem_we  output  1  write strobe qualifying mem_req.
REQ-014 SHALL have port mem_addr  output  32  word address, bits [1:0] = 00.
REQ-015 SHALL have port mem_wdata  output  32  write data.
REQ-016 SHALL have port resp_valid  output  1  resp_data is valid this cycle.
REQ-017 SHALL have port resp_owner  output  1  0 = instruction side, 1 = data side.
REQ-018 SHALL have port resp_idx  output  3  word index within line for the instruction burst; 0 for data.
REQ-019 SHALL have port resp_data  output  32  returned word.
REQ-020 SHALL have ports i_done, d_done  output  1 each  one-cycle completion pulses.
REQ-021 SHALL have ports stall_if, stall_mem  output  1 each  pipeline freeze requests.

Function
REQ-022 SHALL implement FSM states IDLE, I_FILL, D_RD, D_WR, DONE.
REQ-023 In IDLE, SHALL grant d_req over i_req when both are high (fixed data priority); d_we selects D_WR or D_RD; i_req alone selects I_FILL.
REQ-024 At grant, SHALL latch the address: line base {i_addr[31:2+log2(WORDS_PER_LINE)], zeros} for I, d_addr[31:2] for D; SHALL latch d_wdata; SHALL clear the beat counter.
REQ-025 mem_req, mem_we, mem_addr and mem_wdata SHALL be registered; mem_req SHALL be high in every cycle of I_FILL, D_RD and D_WR, starting the cycle after the grant edge.
REQ-026 In I_FILL, mem_addr SHALL be line base + 4*beat; beat SHALL increment on each mem_ready and wrap to 0 after WORDS_PER_LINE-1.
REQ-027 On each mem_ready in I_FILL, SHALL assert resp_valid=1, resp_owner=0, resp_idx=beat and resp_data=mem_rdata in the same cycle (combinational pass-through).
REQ-028 In D_RD, the first mem_ready SHALL produce resp_valid=1, resp_owner=1, resp_idx=0 and resp_data=mem_rdata.
REQ-029 In D_WR, mem_we SHALL be 1 and mem_wdata SHALL be the latched store data; mem_ready completes the access with no resp_valid.
REQ-030 The final mem_ready of a transaction SHALL move the FSM to DONE; DONE SHALL pulse i_done or d_done, matching the owner, for exactly one cycle; mem_req SHALL be 0 in DONE.
REQ-031 DONE SHALL always return to IDLE without sampling requests, guaranteeing one idle cycle between transactions.
REQ-032 Once granted, a transaction SHALL run to completion even if its req drops; the done pulse SHALL still occur.
REQ-033 A request arriving while busy SHALL wait; no request SHALL be lost while held.
REQ-034 SHALL compute stall_mem = d_req & ~d_done combinationally.
REQ-035 SHALL compute stall_if = (i_req & ~i_done) | stall_mem combinationally.
REQ-036 mem_ready outside I_FILL, D_RD or D_WR SHALL be ignored.

Reset
REQ-037 RST_N=0 at a rising edge SHALL force state IDLE, clear beat and latches, and set mem_req, mem_we, mem_addr, mem_wdata, i_done and d_done to 0 after that edge; an in-flight burst is abandoned.
REQ-038 While RST_N=0, resp_valid, stall_if and stall_mem SHALL be 0.

Verification
REQ-039 i_req=1, i_addr=0x104, mem_ready every cycle -> mem_addr 0x100, 0x104, 0x108, 0x10C on successive cycles; resp_idx 0..3; i_done pulses the cycle after the fourth beat.
REQ-040 i_req and d_req rise the same cycle, d_we=0, d_addr=0x20 -> D_RD served first (mem_addr 0x20, resp_owner=1), then DONE, IDLE, then I_FILL; stall_if stays high throughout.
REQ-041 d_req=1, d_we=1, d_addr=0x44, d_wdata=0xDEADBEEF, mem_ready delayed 3 cycles -> mem_req/mem_we held with mem_addr 0x44 and data 0xDEADBEEF for 3 cycles; d_done pulses once; stall_mem drops in the d_done cycle.
REQ-042 RST_N low during beat 2 of an I_FILL -> mem_req=0 after the edge, state IDLE; no i_done pulse; after release a new fill restarts at beat 0.
REQ-043 i_req dropped mid-burst -> burst completes all WORDS_PER_LINE beats; i_done still pulses once.
